serial_operand_feeder: RTL

Upstream stage of the 4-bit serial adder. Accepts two parallel WIDTH-bit operands and a carry-in through a valid/ready handshake, then drives them out LSB-first, one bit per clock, on the adder's serial a/b inputs. Holds carry-in constant for the whole operation. Sequences the adder's reset so that the adder's bit counter and isValid line up with bit 0. Signals completion so the downstream collector knows when to sample y/carryout.

---
 rtl/serial_operand_feeder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial operand feeder for the serial adder: handshake, adder reset, LSB-first shift, drain, done.
// Optional SERIAL_FEEDER_BACK2BACK_EN: accept the next request in the final DRAIN cycle and skip IDLE.
module serial_operand_feeder #(
    parameter int WIDTH        = 4,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     in_cin,
    output logic                     a_ser,
    output logic                     b_ser,
    output logic                     cin_out,
    output logic                     adder_rst,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     done
);

    localparam int IW = $clog2(WIDTH);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [IW-1:0]   r_bit_idx;
    logic [DW-1:0]   r_drain_cnt;
    logic            r_cin;
    logic            r_done;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_last_bit;
    logic            w_drain_last;

    assign w_last_bit   = (r_bit_idx == IW'(WIDTH - 1));
    assign w_drain_last = (r_drain_cnt == DW'(DRAIN_CYCLES - 1));
    assign w_accept     = in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_last_bit) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_last) begin
`ifdef SERIAL_FEEDER_BACK2BACK_EN
                    w_in_ready = 1'b1;
                    w_next     = in_valid ? S_CLEAR : S_IDLE;
`else
                    w_next = S_IDLE;
`endif
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operands and carry-in load only on accept; shift registers advance only in SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_cin       <= 1'b0;
            r_bit_idx   <= '0;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sh_a <= in_a;
                r_sh_b <= in_b;
                r_cin  <= in_cin;
            end else if (r_state == S_SHIFT) begin
                r_sh_a <= {1'b0, r_sh_a[WIDTH-1:1]};
                r_sh_b <= {1'b0, r_sh_b[WIDTH-1:1]};
            end

            if (r_state == S_SHIFT) begin
                r_bit_idx <= w_last_bit ? '0 : r_bit_idx + IW'(1);
            end else begin
                r_bit_idx <= '0;
            end

            if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + DW'(1);
            end else begin
                r_drain_cnt <= '0;
            end

            r_done <= (r_state == S_DRAIN) && w_drain_last;
        end
    end

    assign in_ready  = w_in_ready;
    assign a_ser     = (r_state == S_SHIFT) && r_sh_a[0];
    assign b_ser     = (r_state == S_SHIFT) && r_sh_b[0];
    assign cin_out   = r_cin;
    assign adder_rst = (r_state == S_CLEAR);
    assign busy      = (r_state != S_IDLE);
    assign bit_idx   = r_bit_idx;
    assign done      = r_done;

endmodule
